// File: rtl/alu_pkg.sv
// Shared op codes, FSM states and flag bit positions
// for the multi-cycle ALU.
package alu_pkg;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_NOT  = 4'b0010;
    localparam logic [3:0] OP_AND  = 4'b0011;
    localparam logic [3:0] OP_OR   = 4'b0100;
    localparam logic [3:0] OP_XOR  = 4'b0101;
    localparam logic [3:0] OP_SLT  = 4'b0110;
    localparam logic [3:0] OP_EQ   = 4'b0111;
    localparam logic [3:0] OP_SLTU = 4'b1000;
    localparam logic [3:0] OP_MUL  = 4'b1001;
    localparam logic [3:0] OP_SHL  = 4'b1010;
    localparam logic [3:0] OP_SHR  = 4'b1011;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int F_N = 3;
    localparam int F_Z = 2;
    localparam int F_C = 1;
    localparam int F_V = 0;

endpackage

// File: rtl/alu_mul_iter.sv
// Shift-add multiplier, one bit of b per cycle, LSB first.
// done/product are valid combinationally on the last iteration edge.
module alu_mul_iter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               busy_q, busy_d;

    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (start) begin
            acc_d    = '0;
            mcand_d  = {{WIDTH{1'b0}}, a};
            mplier_d = b;
            cnt_d    = '0;
            busy_d   = 1'b1;
        end else if (busy_q) begin
            acc_d    = acc_q + (mplier_q[0] ? mcand_q : '0);
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST) busy_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy    = busy_q;
    assign done    = busy_q && (cnt_q == LAST);
    assign product = acc_d;

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU: single-cycle ops, iterative multiply,
// registered result/flags behind a valid/ready handshake.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH  = 4,
    parameter bit MUL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [3:0]       flags,
    output logic             illegal
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             illegal_q, illegal_d;

    logic             accept, is_mul;
    logic             mul_busy, mul_done;
    logic [2*WIDTH-1:0] mul_prod;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] alu_res, nres;
    logic             alu_c, alu_v, alu_ill;
    logic             nc, nv, load;

    assign accept = in_valid && (state_q == IDLE);
    assign is_mul = (op == OP_MUL) && MUL_EN;

    if (MUL_EN) begin : g_mul
        alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (accept && is_mul),
            .a       (a),
            .b       (b),
            .busy    (mul_busy),
            .done    (mul_done),
            .product (mul_prod)
        );
    end else begin : g_nomul
        assign mul_busy = 1'b0;
        assign mul_done = 1'b0;
        assign mul_prod = '0;
    end

    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_v   = 1'b0;
        alu_ill = 1'b0;
        sum     = {1'b0, a} + {1'b0, b};
        diff    = {1'b0, a} - {1'b0, b};
        unique case (op)
            OP_ADD: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) &&
                          (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) &&
                          (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_NOT:  alu_res = ~a;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_XOR:  alu_res = a ^ b;
            OP_SLT:  alu_res = WIDTH'($signed(a) < $signed(b));
            OP_EQ:   alu_res = WIDTH'(a == b);
            OP_SLTU: alu_res = WIDTH'(a < b);
            OP_MUL:  alu_ill = !MUL_EN;
            OP_SHL:  alu_res = (32'(b) >= WIDTH) ? '0 : a << b;
            OP_SHR:  alu_res = (32'(b) >= WIDTH) ? '0 : a >> b;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        flags_d   = flags_q;
        illegal_d = illegal_q;
        load      = 1'b0;
        nres      = '0;
        nc        = 1'b0;
        nv        = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in_valid && is_mul) begin
                    state_d = MUL;
                end else if (in_valid) begin
                    state_d   = DONE;
                    load      = 1'b1;
                    nres      = alu_res;
                    nc        = alu_c;
                    nv        = alu_v;
                    illegal_d = alu_ill;
                end
            end
            MUL: begin
                if (mul_busy && mul_done) begin
                    state_d   = DONE;
                    load      = 1'b1;
                    nres      = mul_prod[WIDTH-1:0];
                    nv        = |mul_prod[2*WIDTH-1:WIDTH];
                    illegal_d = 1'b0;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        if (load) begin
            result_d     = nres;
            flags_d[F_N] = nres[WIDTH-1];
            flags_d[F_Z] = ~|nres;
            flags_d[F_C] = nc;
            flags_d[F_V] = nv;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            result_q  <= '0;
            flags_q   <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            flags_q   <= flags_d;
            illegal_q <= illegal_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign result    = result_q;
    assign flags     = flags_q;
    assign illegal   = illegal_q;

endmodule
